// File: rtl/alu_serial_slice.sv
// Nibble-serial 74181-style ALU: one SLICE_W-bit slice plus a carry register, valid/ready on both sides.
// Latency: accept at edge e0, out_valid after edge e0+NSLICE; at least NSLICE+2 cycles per operation.
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE. Flag outputs behind ALU_SERIAL_FLAGS_EN.
module alu_serial_slice #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             Cn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cn16
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             AeqB,
  output logic             Zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [3:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
  } op_t;

  logic [1:0]             state;
  logic [KW-1:0]          k;
  logic                   carry;
  op_t                    op_q;
  // Slices finished so far, assembled from the top down as operands shift right.
  logic [WIDTH-SLICE_W-1:0] work;
  logic [WIDTH-1:0]       f_q;
  logic                   cn16_q;

  logic [SLICE_W-1:0]     sa;
  logic [SLICE_W-1:0]     sb;
  logic [SLICE_W-1:0]     sx;
  logic [SLICE_W-1:0]     sy;
  logic [SLICE_W:0]       ssum;
  logic [SLICE_W-1:0]     snib;
  logic [WIDTH-1:0]       f_next;

  always_comb begin
    sa   = op_q.a[SLICE_W-1:0];
    sb   = op_q.b[SLICE_W-1:0];
    sx   = sa | (sb & {SLICE_W{op_q.s[0]}}) | (~sb & {SLICE_W{op_q.s[1]}});
    sy   = (sa & ~sb & {SLICE_W{op_q.s[2]}}) | (sa & sb & {SLICE_W{op_q.s[3]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {{SLICE_W{1'b0}}, carry};
    snib = op_q.m ? ~(sx ^ sy) : ssum[SLICE_W-1:0];
    f_next = {snib, work};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      carry  <= 1'b0;
      op_q   <= '0;
      work   <= '0;
      f_q    <= '0;
      cn16_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= '{s: S, a: A, b: B, m: M};
            carry <= ~Cn;
            k     <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          op_q.a <= op_q.a >> SLICE_W;
          op_q.b <= op_q.b >> SLICE_W;
          work   <= f_next[WIDTH-1:SLICE_W];
          carry  <= ssum[SLICE_W];
          k      <= k + 1'b1;
          if (k == K_LAST) begin
            // Publish only the complete result so no partial value is ever visible.
            f_q    <= f_next;
            cn16_q <= op_q.m ? 1'b1 : ~ssum[SLICE_W];
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic aeqb_q;
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aeqb_q <= 1'b0;
      zero_q <= 1'b1;
    end else if (state == ST_CALC && k == K_LAST) begin
      aeqb_q <= &f_next;
      zero_q <= ~|f_next;
    end
  end

  assign AeqB = aeqb_q;
  assign Zero = zero_q;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign F         = f_q;
  assign Cn16      = cn16_q;

endmodule

// File: tb/tb_alu_serial_slice.sv
// Directed table-driven bench for alu_serial_slice, plus backpressure and mid-calculation reset sequences.
module tb_alu_serial_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  S;
  logic [15:0] A;
  logic [15:0] B;
  logic        M;
  logic        Cn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] F;
  logic        Cn16;
`ifdef ALU_SERIAL_FLAGS_EN
  logic        AeqB;
  logic        Zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial_slice #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .A(A), .B(B), .M(M), .Cn(Cn),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .Cn16(Cn16)
`ifdef ALU_SERIAL_FLAGS_EN
    , .AeqB(AeqB), .Zero(Zero)
`endif
  );

  typedef struct packed {
    logic [3:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic        cn;
    logic [15:0] f;
    logic        cn16;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete operation with immediate out_ready once the result appears.
  task automatic do_op(input vec_t v);
    int cyc;
    @(negedge clk);
    S = v.s; A = v.a; B = v.b; M = v.m; Cn = v.cn; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = ~v.a; B = ~v.b; S = ~v.s; M = ~v.m; Cn = ~v.cn;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, 32'd4);
    chk("F", {16'd0, F}, {16'd0, v.f});
    chk("Cn16", {31'd0, Cn16}, {31'd0, v.cn16});
`ifdef ALU_SERIAL_FLAGS_EN
    chk("AeqB", {31'd0, AeqB}, {31'd0, &v.f});
    chk("Zero", {31'd0, Zero}, {31'd0, ~|v.f});
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    //             s      a         b         m     cn    f         cn16
    vecs[0]  = '{4'h0, 16'h0002, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b1};
    vecs[1]  = '{4'h1, 16'h0922, 16'h2464, 1'b0, 1'b1, 16'h2D66, 1'b1};
    vecs[2]  = '{4'h9, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[3]  = '{4'h9, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[4]  = '{4'h6, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'hFFFE, 1'b1};
    vecs[5]  = '{4'h6, 16'hF0F0, 16'hFF00, 1'b1, 1'b0, 16'h0FF0, 1'b1};
    vecs[6]  = '{4'h3, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    vecs[7]  = '{4'h6, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    vecs[8]  = '{4'h6, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{4'h9, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b1};
    vecs[10] = '{4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'hEDCB, 1'b1};

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    S = 4'h9; A = 16'h1111; B = 16'h2222; M = 1'b0; Cn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_F", {16'd0, F}, 32'd0);
    chk("rst_Cn16", {31'd0, Cn16}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_SERIAL_FLAGS_EN
    chk("rst_AeqB", {31'd0, AeqB}, 32'd0);
    chk("rst_Zero", {31'd0, Zero}, 32'd1);
`endif
    @(posedge clk); #1;
    chk("idle_after_rst", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) do_op(vecs[i]);

    // Backpressure: result held in DONE while new requests are refused.
    @(negedge clk);
    S = vecs[1].s; A = vecs[1].a; B = vecs[1].b; M = vecs[1].m; Cn = vecs[1].cn;
    in_valid = 1'b1;
    @(posedge clk); #1;
    S = 4'h9; A = 16'hFFFF; B = 16'h0001; M = 1'b0; Cn = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_latency", cyc, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_F_stable", {16'd0, F}, 32'h2D66);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {31'd0, out_valid}, 32'd0);
    chk("bp_F_hold", {16'd0, F}, 32'h2D66);

    // Reset during the second CALC cycle discards the operation.
    @(negedge clk);
    S = vecs[0].s; A = vecs[0].a; B = vecs[0].b; M = vecs[0].m; Cn = vecs[0].cn;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_F", {16'd0, F}, 32'd0);
    chk("mid_rst_Cn16", {31'd0, Cn16}, 32'd1);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
    end

    do_op(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
